// File: rtl/decim_resampler_pkg.sv
// Shared types and constant helpers for the decimating re-quantiser.
package decim_resampler_pkg;

  typedef enum logic {
    MODE_PICK = 1'b0,
    MODE_AVG  = 1'b1
  } mode_e;

  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int unsigned p = 1; p < v; p = p << 1) r++;
    return r;
  endfunction

  // Code that represents a zero-valued sample at the output.
  function automatic logic [31:0] midscale(input int unsigned w, input bit offset_bin);
    return offset_bin ? (32'd1 << (w - 1)) : 32'd0;
  endfunction

endpackage

// File: rtl/decim_resampler_lane.sv
// One lane: boxcar accumulator, stage-1 capture, round/saturate/offset stage, sticky ovf.
module resampler_lane
  import decim_resampler_pkg::*;
#(
  parameter int IN_W       = 48,
  parameter int OUT_W      = 12,
  parameter int RANGE_H    = 28,
  parameter int DECIM      = 16,
  parameter int OFFSET_BIN = 1
) (
  input  logic             clk,
  input  logic             nreset,
  input  logic             i_valid,
  input  logic             i_first,
  input  logic             i_clr,
  input  logic             i_done,
  input  logic             i_avg,
  input  logic             i_s1_vld,
  input  logic             i_ovf_clr,
  input  logic [IN_W-1:0]  i_data,
  output logic [OUT_W-1:0] o_code,
  output logic             o_ovf
);

  localparam int unsigned     PW      = clog2(DECIM);
  localparam int unsigned     AW      = IN_W + PW;
  localparam logic [OUT_W-1:0] MID    = OUT_W'(midscale(OUT_W, OFFSET_BIN != 0));
  localparam logic [OUT_W-1:0] POSMAX = {1'b0, {(OUT_W-1){1'b1}}};
  localparam logic [OUT_W-1:0] NEGMIN = {1'b1, {(OUT_W-1){1'b0}}};
  localparam logic [OUT_W-1:0] FLIP   = {(OFFSET_BIN != 0), {(OUT_W-1){1'b0}}};

  logic [AW-1:0]          r_acc;
  logic [IN_W-1:0]        r_s1;
  logic [OUT_W-1:0]       r_code;
  logic                   r_ovf;
  logic [AW-1:0]          w_ext;
  logic [AW-1:0]          w_sum;
  logic [IN_W-1:0]        w_avg;
  logic [IN_W:0]          w_rnd;
  logic [IN_W-RANGE_H:0]  w_hi;
  logic                   w_sat;
  logic [OUT_W-1:0]       w_code;
  logic                   w_unused;

  assign w_ext = {{PW{i_data[IN_W-1]}}, i_data};
  assign w_sum = r_acc + w_ext;
  // Dropping the low PW bits of the sum is the arithmetic shift by log2(DECIM).
  assign w_avg = w_sum[AW-1:PW];

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      r_acc <= '0;
      r_s1  <= '0;
    end else begin
      if (i_valid)    r_acc <= i_first ? w_ext : w_sum;
      else if (i_clr) r_acc <= '0;
      if (i_done)     r_s1  <= i_avg ? w_avg : i_data;
    end
  end

  generate
    if (RANGE_H >= OUT_W) begin : g_rnd
      assign w_rnd = {r_s1[IN_W-1], r_s1} + ((IN_W+1)'(1) << (RANGE_H - OUT_W));
    end else begin : g_nornd
      assign w_rnd = {r_s1[IN_W-1], r_s1};
    end
  endgenerate

  assign w_hi  = w_rnd[IN_W:RANGE_H];
  assign w_sat = ~((&w_hi) | ~(|w_hi));

  always_comb begin
    w_code = w_rnd[RANGE_H -: OUT_W];
    if (w_sat) w_code = w_rnd[IN_W] ? NEGMIN : POSMAX;
    w_code = w_code ^ FLIP;
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      r_code <= MID;
      r_ovf  <= 1'b0;
    end else begin
      if (i_s1_vld) r_code <= w_code;
      if (i_s1_vld && w_sat) r_ovf <= 1'b1;
      else if (i_ovf_clr)    r_ovf <= 1'b0;
    end
  end

  assign o_code   = r_code;
  assign o_ovf    = r_ovf;
  assign w_unused = ^{w_rnd, w_sum[PW-1:0]};

endmodule

// File: rtl/decim_resampler.sv
// Decimating re-quantiser top: shared phase counter, mode latch, valid pipeline, lanes.
module decim_resampler
  import decim_resampler_pkg::*;
#(
  parameter int IN_W       = 48,
  parameter int OUT_W      = 12,
  parameter int RANGE_H    = 28,
  parameter int DECIM      = 16,
  parameter int CHANNELS   = 2,
  parameter int OFFSET_BIN = 1
) (
  input  logic                      clk,
  input  logic                      nreset,
  input  logic                      in_valid,
  input  logic [CHANNELS*IN_W-1:0]  in_data,
  input  logic                      mode,
  input  logic                      sync_clr,
  input  logic                      ovf_clr,
  output logic                      out_valid,
  output logic [CHANNELS*OUT_W-1:0] out_data,
  output logic [CHANNELS-1:0]       ovf
);

  localparam int unsigned PW = clog2(DECIM);

  logic [PW-1:0] r_phase;
  mode_e         r_mode;
  logic          r_s1_vld;
  logic          r_out_vld;
  logic          w_first;
  logic          w_done;
  logic          w_avg;

  // sync_clr with in_valid makes this sample phase 0 of a fresh group.
  assign w_first = in_valid & (sync_clr | (r_phase == '0));
  assign w_done  = in_valid & ~sync_clr & (r_phase == PW'(DECIM - 1));
  assign w_avg   = (w_first ? mode_e'(mode) : r_mode) == MODE_AVG;

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      r_phase   <= '0;
      r_mode    <= MODE_PICK;
      r_s1_vld  <= 1'b0;
      r_out_vld <= 1'b0;
    end else begin
      if (sync_clr)      r_phase <= in_valid ? PW'(1) : '0;
      else if (in_valid) r_phase <= r_phase + PW'(1);
      if (w_first)       r_mode  <= mode_e'(mode);
      r_s1_vld  <= w_done;
      r_out_vld <= r_s1_vld;
    end
  end

  assign out_valid = r_out_vld;

  for (genvar k = 0; k < CHANNELS; k++) begin : g_lane
    resampler_lane #(
      .IN_W      (IN_W),
      .OUT_W     (OUT_W),
      .RANGE_H   (RANGE_H),
      .DECIM     (DECIM),
      .OFFSET_BIN(OFFSET_BIN)
    ) u_lane (
      .clk      (clk),
      .nreset   (nreset),
      .i_valid  (in_valid),
      .i_first  (w_first),
      .i_clr    (sync_clr),
      .i_done   (w_done),
      .i_avg    (w_avg),
      .i_s1_vld (r_s1_vld),
      .i_ovf_clr(ovf_clr),
      .i_data   (in_data[k*IN_W +: IN_W]),
      .o_code   (out_data[k*OUT_W +: OUT_W]),
      .o_ovf    (ovf[k])
    );
  end

endmodule
